// File: rtl/sbox_arb_pkg.sv
// Shared types and the AES forward S-box table for the S-box share arbiter.
package sbox_arb_pkg;

  localparam int REG_SIZE = 32;
  localparam int VEC_SIZE = 4;

  typedef logic [VEC_SIZE-1:0][REG_SIZE-1:0] state_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/sub_bytes.sv
// Combinational AES SubBytes over a vecSize x regSize state; regSize must be a multiple of 8.
module sub_bytes
  import sbox_arb_pkg::*;
#(
  parameter int regSize = 32,
  parameter int vecSize = 4
) (
  input  logic [vecSize-1:0][regSize-1:0] state_in,
  output logic [vecSize-1:0][regSize-1:0] state_out
);

  localparam int BYTES = regSize / 8;

  for (genvar w = 0; w < vecSize; w++) begin : g_word
    for (genvar b = 0; b < BYTES; b++) begin : g_byte
      assign state_out[w][8*b +: 8] = sbox_byte(state_in[w][8*b +: 8]);
    end
  end

endmodule

// File: rtl/sbox_share_arbiter.sv
// Round-robin share of one sub_bytes datapath among NREQ requesters, with a one-deep response register.
// Optional sticky grant enabled by defining SBOX_ARB_LOCK_EN (adds the req_lock port).
module sbox_share_arbiter
  import sbox_arb_pkg::*;
#(
  parameter int regSize = 32,
  parameter int vecSize = 4,
  parameter int NREQ    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NREQ-1:0]                            req_valid,
  input  logic [NREQ-1:0][vecSize-1:0][regSize-1:0]  req_state,
  output logic [NREQ-1:0]                            req_ready,
  output logic                                       rsp_valid,
  input  logic                                       rsp_ready,
  output logic [vecSize-1:0][regSize-1:0]            rsp_state,
  output logic [$clog2(NREQ)-1:0]                    rsp_id,
  output logic                                       busy,
  output logic [CNT_W-1:0]                           grant_cnt
`ifdef SBOX_ARB_LOCK_EN
  ,
  input  logic [NREQ-1:0]                            req_lock
`endif
);

  localparam int ID_W = $clog2(NREQ);

  fsm_t                           state;
  logic [ID_W-1:0]                rr_ptr;
  logic [ID_W-1:0]                rr_winner;
  logic [ID_W-1:0]                winner;
  logic [ID_W-1:0]                next_ptr;
  logic                           any_valid;
  logic                           space;
  logic                           transfer;
  logic                           hold_lock;
  logic [vecSize-1:0][regSize-1:0] sel_state;
  logic [vecSize-1:0][regSize-1:0] sub_state;

  // First valid requester found scanning upward from ptr, wrapping modulo NREQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                              input logic [ID_W-1:0] ptr);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && valid[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // rsp_id always names the most recent winner, so it doubles as the lock owner.
  always_comb begin
    any_valid = |req_valid;
    space     = (state == EMPTY) | rsp_ready;
    transfer  = space & any_valid;
    rr_winner = rr_pick(req_valid, rr_ptr);
`ifdef SBOX_ARB_LOCK_EN
    hold_lock = req_lock[rsp_id] & req_valid[rsp_id];
`else
    hold_lock = 1'b0;
`endif
    winner    = hold_lock ? rsp_id : rr_winner;
    if (int'(winner) == NREQ - 1) begin
      next_ptr = '0;
    end else begin
      next_ptr = winner + ID_W'(1);
    end
    req_ready = transfer ? (NREQ'(1) << winner) : '0;
    sel_state = req_state[winner];
  end

  sub_bytes #(
    .regSize (regSize),
    .vecSize (vecSize)
  ) u_sub_bytes (
    .state_in  (sel_state),
    .state_out (sub_state)
  );

  // A locked re-grant keeps rr_ptr so round-robin resumes where it left off.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      rsp_state <= '0;
      rsp_id    <= '0;
      grant_cnt <= '0;
      rr_ptr    <= '0;
    end else if (transfer) begin
      state     <= FULL;
      rsp_state <= sub_state;
      rsp_id    <= winner;
      grant_cnt <= grant_cnt + CNT_W'(1);
      if (!hold_lock) begin
        rr_ptr <= next_ptr;
      end
    end else if (rsp_ready) begin
      state <= EMPTY;
    end
  end

  assign rsp_valid = (state == FULL);
  assign busy      = rsp_valid | any_valid;

endmodule
